// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Byte UART transmitter (8 data bits, LSB first, 1 or 2 stop bits)
//            with a small input FIFO and a running 32-bit sum of sent bytes.
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_serial,
  output logic        o_idle,
  output logic        o_done,
  output logic [31:0] o_sum
);

  localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_CYC_MAX = STOP_BITS * CYCLES_PER_BIT - 1;
  localparam int c_CYC_W   = (c_CYC_MAX > 1) ? $clog2(c_CYC_MAX + 1) : 1;

  localparam logic [c_CYC_W-1:0] c_BIT_END  = c_CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [c_CYC_W-1:0] c_STOP_END = c_CYC_W'(c_CYC_MAX);
  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  // Serializer
  state_t             r_state;
  logic [c_CYC_W-1:0] r_cyc;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic [7:0]         r_byte;
  logic               r_serial;
  logic               r_done;
  logic [31:0]        r_sum;

  logic               w_push;
  logic               w_pop;
  logic               w_not_empty;
  logic               w_stop_end;
  logic [7:0]         w_head;

  assign w_not_empty = (r_count != '0);
  assign w_stop_end  = (r_state == S_STOP) && (r_cyc == c_STOP_END);
  assign w_push      = i_valid && o_ready;
  // The serializer takes the head either from rest or straight out of a stop bit.
  assign w_pop       = w_not_empty && ((r_state == S_IDLE) || w_stop_end);
  assign w_head      = r_mem[r_rptr];

  assign o_ready  = (r_count != c_FULL);
  assign o_idle   = (r_state == S_IDLE) && !w_not_empty;
  assign o_serial = r_serial;
  assign o_done   = r_done;
  assign o_sum    = r_sum;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_serial <= 1'b1;
      r_done   <= 1'b0;
      r_sum    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          r_cyc    <= '0;
          if (w_pop) begin
            r_shift  <= w_head;
            r_byte   <= w_head;
            r_serial <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (r_cyc == c_BIT_END) begin
            r_cyc    <= '0;
            r_bit    <= '0;
            r_serial <= r_shift[0];
            r_state  <= S_DATA;
          end else begin
            r_cyc <= r_cyc + c_CYC_W'(1);
          end
        end

        S_DATA: begin
          if (r_cyc == c_BIT_END) begin
            r_cyc <= '0;
            if (r_bit == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= S_STOP;
            end else begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_serial <= r_shift[1];
              r_bit    <= r_bit + 3'd1;
            end
          end else begin
            r_cyc <= r_cyc + c_CYC_W'(1);
          end
        end

        S_STOP: begin
          if (w_stop_end) begin
            r_done <= 1'b1;
            r_sum  <= r_sum + {24'd0, r_byte};
            r_cyc  <= '0;
            // Chain straight into the next start bit so queued frames abut.
            if (w_pop) begin
              r_shift  <= w_head;
              r_byte   <= w_head;
              r_serial <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_serial <= 1'b1;
              r_state  <= S_IDLE;
            end
          end else begin
            r_cyc <= r_cyc + c_CYC_W'(1);
          end
        end

        default: begin
          r_serial <= 1'b1;
          r_cyc    <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// Testbench for uart_tx: directed steps, with a line-decoding monitor acting as
// the receiver and a queue of accepted bytes as the scoreboard.
module tb_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d0_data, d1_data;
  logic        d0_valid, d1_valid;
  logic        d0_ready, d0_serial, d0_idle, d0_done;
  logic        d1_ready, d1_serial, d1_idle, d1_done;
  logic [31:0] d0_sum, d1_sum;

  always #5 clk = ~clk;

  uart_tx #(.CYCLES_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(d0_data), .i_valid(d0_valid),
    .o_ready(d0_ready), .o_serial(d0_serial), .o_idle(d0_idle),
    .o_done(d0_done), .o_sum(d0_sum)
  );

  uart_tx #(.CYCLES_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_data(d1_data), .i_valid(d1_valid),
    .o_ready(d1_ready), .o_serial(d1_serial), .o_idle(d1_idle),
    .o_done(d1_done), .o_sum(d1_sum)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          st0[$];
  int          st1[$];
  bit          m_act[2];
  bit          m_pend[2];
  bit          m_shape[2];
  int          m_idx[2];
  int          m_frames[2];
  logic [7:0]  m_byte[2];
  logic [31:0] m_sum[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: decodes frames cycle by cycle and checks them against the queue.
  task automatic mon_step(input int d, input logic ser, input logic done,
                          input logic [31:0] sum, input int sb);
    int flen;
    int b;
    logic [7:0] exp_b;
    if (rst_n !== 1'b1) begin
      m_act[d]  = 1'b0;
      m_pend[d] = 1'b0;
      m_sum[d]  = '0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    check((d == 0) ? "done0" : "done1", {31'd0, done}, {31'd0, m_pend[d]});
    if (m_pend[d]) begin
      check((d == 0) ? "sum0" : "sum1", sum, m_sum[d]);
      m_pend[d] = 1'b0;
    end
    if (!m_act[d] && ser === 1'b0) begin
      m_act[d]   = 1'b1;
      m_idx[d]   = 0;
      m_shape[d] = 1'b1;
      m_byte[d]  = '0;
      if (d == 0) st0.push_back(cyc); else st1.push_back(cyc);
    end
    if (m_act[d]) begin
      flen = (9 + sb) * CPB;
      if (m_idx[d] < CPB) begin
        if (ser !== 1'b0) m_shape[d] = 1'b0;
      end else if (m_idx[d] < 9 * CPB) begin
        b = (m_idx[d] - CPB) / CPB;
        if ((m_idx[d] - CPB) % CPB == 0) m_byte[d][b] = ser;
        else if (ser !== m_byte[d][b]) m_shape[d] = 1'b0;
      end else if (ser !== 1'b1) begin
        m_shape[d] = 1'b0;
      end
      m_idx[d]++;
      if (m_idx[d] == flen) begin
        m_act[d]  = 1'b0;
        m_pend[d] = 1'b1;
        m_frames[d]++;
        check((d == 0) ? "frame_shape0" : "frame_shape1", {31'd0, m_shape[d]}, 32'd1);
        if (d == 0) begin
          check("frame_expected0", {31'd0, (q0.size() != 0)}, 32'd1);
          exp_b = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
        end else begin
          check("frame_expected1", {31'd0, (q1.size() != 0)}, 32'd1);
          exp_b = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
        end
        check((d == 0) ? "rx_byte0" : "rx_byte1", {24'd0, m_byte[d]}, {24'd0, exp_b});
        m_sum[d] = m_sum[d] + {24'd0, m_byte[d]};
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, d0_serial, d0_done, d0_sum, 1);
    mon_step(1, d1_serial, d1_done, d1_sum, 2);
  end

  // Called one delta after a posedge; returns one delta after the accepting posedge.
  task automatic send(input int d, input logic [7:0] b);
    int g = 0;
    if (d == 0) begin d0_valid = 1'b1; d0_data = b; end
    else        begin d1_valid = 1'b1; d1_data = b; end
    while (((d == 0) ? d0_ready : d1_ready) !== 1'b1 && g < 200) begin
      @(posedge clk); #1; g++;
    end
    check("send_ready", {31'd0, (g < 200)}, 32'd1);
    @(posedge clk);
    if (d == 0) q0.push_back(b); else q1.push_back(b);
    #1;
    if (d == 0) d0_valid = 1'b0; else d1_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, output int at);
    int g = 0;
    do begin
      @(negedge clk); g++;
    end while (((d == 0) ? d0_idle : d1_idle) !== 1'b1 && g < budget);
    at = cyc;
    check((d == 0) ? "idle0" : "idle1", {31'd0, ((d == 0) ? d0_idle : d1_idle)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    st0.delete();
    st1.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, g, t, acc, f0;
    logic [7:0]  k, b;
    logic [31:0] model;

    rst_n = 1'b0; d0_valid = 1'b0; d1_valid = 1'b0; d0_data = '0; d1_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_serial0", {31'd0, d0_serial}, 32'd1);
    check("rst_ready0",  {31'd0, d0_ready},  32'd1);
    check("rst_idle0",   {31'd0, d0_idle},   32'd1);
    check("rst_done0",   {31'd0, d0_done},   32'd0);
    check("rst_sum0",    d0_sum,             32'd0);
    check("rst_serial1", {31'd0, d1_serial}, 32'd1);
    check("rst_idle1",   {31'd0, d1_idle},   32'd1);
    check("rst_sum1",    d1_sum,             32'd0);
    @(posedge clk); #1;

    // Single byte 0x55: start at N+1, done at N+41
    send(0, 8'h55);
    n = cyc;
    @(negedge clk);
    check("t1_line_before_pop", {31'd0, d0_serial}, 32'd1);
    check("t1_idle_after_push", {31'd0, d0_idle},   32'd0);
    @(negedge clk);
    check("t1_start_low", {31'd0, d0_serial}, 32'd0);
    g = 0;
    while (d0_done !== 1'b1 && g < 60) begin @(negedge clk); g++; end
    check("t1_done_edge", 32'(cyc), 32'(n + 41));
    check("t1_sum", d0_sum, 32'h55);
    @(posedge clk); #1;

    // Back-to-back 0x01..0x03
    do_reset();
    send(0, 8'h01);
    send(0, 8'h02);
    send(0, 8'h03);
    wait_idle(0, 200, t);
    check("t2_sum", d0_sum, 32'h06);
    check("t2_frames", 32'(st0.size()), 32'd3);
    if (st0.size() == 3) begin
      check("t2_gap01", 32'(st0[1] - st0[0]), 32'd40);
      check("t2_gap12", 32'(st0[2] - st0[1]), 32'd40);
      check("t2_idle_edge", 32'(t), 32'(st0[2] + 40));
    end

    // FIFO full with i_valid held
    do_reset();
    k = 8'h10; acc = 0; g = 0;
    d0_valid = 1'b1; d0_data = k;
    while (g < 20) begin
      @(negedge clk);
      if (d0_ready !== 1'b1) break;
      @(posedge clk);
      q0.push_back(k); k = k + 8'd1; acc++;
      #1 d0_data = k;
      g++;
    end
    check("t3_accepted", 32'(acc), 32'd5);
    check("t3_ready_low", {31'd0, d0_ready}, 32'd0);
    g = 0;
    while (d0_done !== 1'b1 && g < 60) begin @(negedge clk); g++; end
    check("t3_done_seen", {31'd0, d0_done}, 32'd1);
    check("t3_ready_after_pop", {31'd0, d0_ready}, 32'd1);
    @(posedge clk);
    q0.push_back(k); k = k + 8'd1;
    #1 d0_valid = 1'b0;
    @(negedge clk);
    check("t3_full_again", {31'd0, d0_ready}, 32'd0);
    wait_idle(0, 300, t);
    check("t3_sum", d0_sum, 32'h6F);

    // Reset during DATA bit 3 of 0x00 with two bytes queued
    do_reset();
    send(0, 8'h00);
    send(0, 8'h11);
    send(0, 8'h22);
    repeat (16) @(posedge clk);
    #1;
    check("t4_in_bit3", {31'd0, d0_serial}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t4_serial", {31'd0, d0_serial}, 32'd1);
    check("t4_sum",    d0_sum,             32'd0);
    check("t4_ready",  {31'd0, d0_ready},  32'd1);
    check("t4_idle",   {31'd0, d0_idle},   32'd1);
    check("t4_done",   {31'd0, d0_done},   32'd0);
    repeat (60) @(negedge clk);
    @(posedge clk); #1;
    send(0, 8'hA5);
    wait_idle(0, 100, t);
    check("t4_after_sum", d0_sum, 32'hA5);

    // Two stop bits: 44-clock frames, repeated 0xFF
    do_reset();
    for (int i = 0; i < 6; i++) send(1, 8'hFF);
    wait_idle(1, 400, t);
    check("t5_sum", d1_sum, 32'h5FA);
    check("t5_frames", 32'(st1.size()), 32'd6);
    if (st1.size() == 6) begin
      for (int i = 1; i < 6; i++) check("t5_gap", 32'(st1[i] - st1[i-1]), 32'd44);
      check("t5_idle_edge", 32'(t), 32'(st1[5] + 44));
    end

    // Loopback of 256 random bytes
    do_reset();
    model = '0;
    f0 = m_frames[0];
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      model = model + {24'd0, b};
      send(0, b);
    end
    wait_idle(0, 300, t);
    check("t6_frames", 32'(m_frames[0] - f0), 32'd256);
    check("t6_queue_empty", 32'(q0.size()), 32'd0);
    check("t6_sum_model", d0_sum, model);
    check("t6_rx_sum", m_sum[0], d0_sum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
